// File: rtl/led_matrix_pwm_driver.sv
// Row-scanned bi-colour LED matrix driver: per-pixel PWM intensity, two frame
// buffers exchanged only at frame boundaries, and a dark gap before every row.
module led_matrix_pwm_driver #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int BW       = 2,
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 16,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int W       = 2 * COLS * BW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [RW-1:0]   addr_i,
    input  logic [W-1:0]    data_i,
    input  logic            wren_i,
    output logic [W-1:0]    q_o,
    input  logic            swap_i,
    input  logic            en_i,
    output logic            swap_pending_o,
    output logic            frame_start_o,
    output logic [COLS-1:0] l_green_o,
    output logic [COLS-1:0] l_red_o,
    output logic [ROWS-1:0] l_vcc_o
);
    localparam int NSLOT = (1 << BW) - 1;
    localparam int CMAX  = (PRESCALE > BLANK) ? PRESCALE : BLANK;
    localparam int CW    = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [BW-1:0] SLOT_LAST  = BW'(NSLOT - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    typedef enum logic {PH_BLANK = 1'b0, PH_PWM = 1'b1} phase_t;

    logic [W-1:0]    buf_q [2][ROWS];
    logic            front_q;
    logic            pending_q;
    phase_t          phase_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   slot_q;
    logic [W-1:0]    row_data_q;
    logic [W-1:0]    q_q;
    logic            fs_q;
    logic [COLS-1:0] green_q;
    logic [COLS-1:0] red_q;
    logic [ROWS-1:0] vcc_q;

    logic            back_idx;
    logic            addr_ok;
    logic            at_boundary;
    logic [COLS-1:0] green_on;
    logic [COLS-1:0] red_on;
    logic [ROWS-1:0] row_onehot;

    assign back_idx   = ~front_q;
    assign row_onehot = ROWS'(1) << row_q;

    // Only non-power-of-two geometries can present an out-of-range address.
    if ((1 << RW) == ROWS) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = (addr_i < RW'(ROWS));
    end

    genvar gi;
    for (gi = 0; gi < COLS; gi++) begin : g_col
        assign green_on[gi] = row_data_q[gi*BW +: BW] > slot_q;
        assign red_on[gi]   = row_data_q[COLS*BW + gi*BW +: BW] > slot_q;
    end

    assign at_boundary = en_i && (phase_q == PH_PWM) && (slot_q == SLOT_LAST) &&
                         (cnt_q == PRE_LAST) && (row_q == ROW_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_q[0][r] <= '0;
                buf_q[1][r] <= '0;
            end
        end else if (wren_i && addr_ok) begin
            buf_q[back_idx][addr_i] <= data_i;
        end
    end

    // Pin registers are loaded from the current scan position, so the pins
    // trail the counters by one clock and a held position is replayed intact.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            front_q    <= 1'b0;
            pending_q  <= 1'b0;
            phase_q    <= PH_BLANK;
            row_q      <= '0;
            cnt_q      <= '0;
            slot_q     <= '0;
            row_data_q <= '0;
            q_q        <= '0;
            fs_q       <= 1'b0;
            green_q    <= '1;
            red_q      <= '1;
            vcc_q      <= '0;
        end else begin
            q_q <= addr_ok ? buf_q[back_idx][addr_i] : '0;

            if (at_boundary && pending_q) begin
                front_q   <= ~front_q;
                pending_q <= 1'b0;
            end else if (swap_i) begin
                pending_q <= 1'b1;
            end

            if (en_i) begin
                fs_q    <= (phase_q == PH_BLANK) && (cnt_q == '0) && (row_q == '0);
                vcc_q   <= (phase_q == PH_PWM) ? row_onehot : '0;
                green_q <= (phase_q == PH_PWM) ? ~green_on : '1;
                red_q   <= (phase_q == PH_PWM) ? ~red_on : '1;

                if (phase_q == PH_BLANK) begin
                    // Front index has already settled by the first blank clock.
                    if (cnt_q == '0) begin
                        row_data_q <= buf_q[front_q][row_q];
                    end
                    if (cnt_q == BLANK_LAST) begin
                        phase_q <= PH_PWM;
                        cnt_q   <= '0;
                        slot_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_q <= '0;
                        if (slot_q == SLOT_LAST) begin
                            slot_q  <= '0;
                            phase_q <= PH_BLANK;
                            row_q   <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end else begin
                fs_q    <= 1'b0;
                vcc_q   <= '0;
                green_q <= '1;
                red_q   <= '1;
            end
        end
    end

    assign q_o            = q_q;
    assign swap_pending_o = pending_q;
    assign frame_start_o  = fs_q;
    assign l_green_o      = green_q;
    assign l_red_o        = red_q;
    assign l_vcc_o        = vcc_q;

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Directed bench for led_matrix_pwm_driver with an 8x8, 2-bit, PRESCALE=4,
// BLANK=2 geometry (row dwell 14 clocks, frame 112 clocks).
module tb_led_matrix_pwm_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;
    logic        swap;
    logic        en;
    logic        pending;
    logic        fs;
    logic [7:0]  l_green;
    logic [7:0]  l_red;
    logic [7:0]  l_vcc;

    int errors = 0;
    int checks = 0;

    led_matrix_pwm_driver #(
        .ROWS(8), .COLS(8), .BW(2), .PRESCALE(4), .BLANK(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data), .wren_i(wren),
        .q_o(q), .swap_i(swap), .en_i(en), .swap_pending_o(pending),
        .frame_start_o(fs), .l_green_o(l_green), .l_red_o(l_red), .l_vcc_o(l_vcc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wren = 1'b0; swap = 1'b0; en = 1'b1; addr = '0; data = '0;
        repeat (3) tick();
        $display("reset asserted for 3 clocks");
        checks++; if (l_vcc !== 8'h00) begin errors++; $display("FAIL reset_vcc: got %h expected %h", l_vcc, 8'h00); end
        checks++; if (l_green !== 8'hff) begin errors++; $display("FAIL reset_green: got %h expected %h", l_green, 8'hff); end
        checks++; if (l_red !== 8'hff) begin errors++; $display("FAIL reset_red: got %h expected %h", l_red, 8'hff); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 32'h0); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected 0", pending); end
        checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", fs); end
        rst = 1'b0;
    endtask

    task automatic test_scan_timing();
        logic [7:0] exp;
        int n;
        tick();
        $display("scan: first clock after reset release");
        checks++; if (fs !== 1'b1) begin errors++; $display("FAIL scan_fs_first: got %b expected 1", fs); end
        checks++; if (l_vcc !== 8'h00) begin errors++; $display("FAIL scan_vcc_0: got %h expected %h", l_vcc, 8'h00); end
        for (int i = 1; i < 32; i++) begin
            tick();
            if (i < 2)       exp = 8'h00;
            else if (i < 14) exp = 8'h01;
            else if (i < 16) exp = 8'h00;
            else if (i < 28) exp = 8'h02;
            else if (i < 30) exp = 8'h00;
            else             exp = 8'h04;
            checks++;
            if (l_vcc !== exp) begin errors++; $display("FAIL scan_vcc_%0d: got %h expected %h", i, l_vcc, exp); end
        end
        n = 31;
        do begin
            tick();
            n++;
        end while (fs !== 1'b1 && n < 300);
        $display("scan: next frame start %0d clocks after first", n);
        checks++; if (n !== 112) begin errors++; $display("FAIL frame_period: got %0d expected %0d", n, 112); end
    endtask

    task automatic test_pwm_levels();
        int n, c_vcc, g0, g1, g2, g3, rlow, ghost, multi;
        wren = 1'b1; addr = 3'd3; data = 32'h0000_001B;
        tick();
        $display("write addr=3 data=%h", data);
        wren = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0;
        $display("swap request");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pwm_pending_set: got %b expected 1", pending); end
        n = 0;
        while (pending === 1'b1 && n < 300) begin tick(); n++; end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL pwm_swap_timeout: got %b expected 0", pending); end
        c_vcc = 0; g0 = 0; g1 = 0; g2 = 0; g3 = 0; rlow = 0; ghost = 0; multi = 0;
        for (int i = 0; i < 112; i++) begin
            tick();
            if (i == 0) begin
                checks++; if (fs !== 1'b1) begin errors++; $display("FAIL pwm_fs_after_swap: got %b expected 1", fs); end
            end
            if ($countones(l_vcc) > 1) multi++;
            if (l_vcc === 8'h00 && (l_green !== 8'hff || l_red !== 8'hff)) ghost++;
            if (l_red !== 8'hff) rlow++;
            if (l_vcc === 8'h08) begin
                c_vcc++;
                if (l_green[0] === 1'b0) g0++;
                if (l_green[1] === 1'b0) g1++;
                if (l_green[2] === 1'b0) g2++;
                if (l_green[3] === 1'b0) g3++;
            end
        end
        $display("pwm row3: vcc=%0d g0=%0d g1=%0d g2=%0d g3=%0d", c_vcc, g0, g1, g2, g3);
        checks++; if (c_vcc !== 12) begin errors++; $display("FAIL pwm_row3_dwell: got %0d expected 12", c_vcc); end
        checks++; if (g0 !== 12) begin errors++; $display("FAIL pwm_level3: got %0d expected 12", g0); end
        checks++; if (g1 !== 8) begin errors++; $display("FAIL pwm_level2: got %0d expected 8", g1); end
        checks++; if (g2 !== 4) begin errors++; $display("FAIL pwm_level1: got %0d expected 4", g2); end
        checks++; if (g3 !== 0) begin errors++; $display("FAIL pwm_level0: got %0d expected 0", g3); end
        checks++; if (rlow !== 0) begin errors++; $display("FAIL pwm_red_dark: got %0d expected 0", rlow); end
        checks++; if (ghost !== 0) begin errors++; $display("FAIL pwm_blank_ghost: got %0d expected 0", ghost); end
        checks++; if (multi !== 0) begin errors++; $display("FAIL pwm_multi_row: got %0d expected 0", multi); end
    endtask

    task automatic test_swap_pending();
        int n, early, r0, glow, pend_hi;
        repeat (20) tick();
        wren = 1'b1; addr = 3'd0; data = 32'h0003_0000;
        tick();
        $display("write addr=0 data=%h", data);
        wren = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0;
        $display("swap request mid-frame");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL swp_pending_set: got %b expected 1", pending); end
        repeat (5) tick();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        $display("second swap request while pending");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL swp_pending_hold: got %b expected 1", pending); end
        early = 0; n = 0;
        while (pending === 1'b1 && n < 300) begin
            if (l_red !== 8'hff) early++;
            tick();
            n++;
        end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL swp_timeout: got %b expected 0", pending); end
        checks++; if (early !== 0) begin errors++; $display("FAIL swp_front_early: got %0d expected 0", early); end
        r0 = 0; glow = 0; pend_hi = 0;
        for (int i = 0; i < 112; i++) begin
            tick();
            if (l_vcc === 8'h01 && l_red[0] === 1'b0) r0++;
            if (l_green !== 8'hff) glow++;
            if (pending !== 1'b0) pend_hi++;
        end
        $display("swap frame: red0=%0d green_low=%0d", r0, glow);
        checks++; if (r0 !== 12) begin errors++; $display("FAIL swp_new_image: got %0d expected 12", r0); end
        checks++; if (glow !== 0) begin errors++; $display("FAIL swp_old_image_gone: got %0d expected 0", glow); end
        checks++; if (pend_hi !== 0) begin errors++; $display("FAIL swp_second_ignored: got %0d expected 0", pend_hi); end
    endtask

    task automatic test_read_write();
        int lit5, r0;
        wren = 1'b1; addr = 3'd5; data = 32'hA5A5_0F0F;
        tick();
        $display("write addr=5 data=%h", data);
        wren = 1'b0;
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rw_same_edge_old: got %h expected %h", q, 32'h0); end
        tick();
        $display("read addr=5 q=%h", q);
        checks++; if (q !== 32'hA5A5_0F0F) begin errors++; $display("FAIL rw_readback: got %h expected %h", q, 32'hA5A5_0F0F); end
        addr = 3'd3;
        tick();
        $display("read addr=3 q=%h", q);
        checks++; if (q !== 32'h0000_001B) begin errors++; $display("FAIL rw_read_row3: got %h expected %h", q, 32'h0000_001B); end
        lit5 = 0; r0 = 0;
        for (int i = 0; i < 112; i++) begin
            tick();
            if (l_vcc === 8'h20 && (l_green !== 8'hff || l_red !== 8'hff)) lit5++;
            if (l_vcc === 8'h01 && l_red[0] === 1'b0) r0++;
        end
        checks++; if (lit5 !== 0) begin errors++; $display("FAIL rw_front_row5: got %0d expected 0", lit5); end
        checks++; if (r0 !== 12) begin errors++; $display("FAIL rw_front_row0: got %0d expected 12", r0); end
    endtask

    task automatic test_enable();
        int n, dark, rem, blank;
        n = 0;
        while (l_vcc !== 8'h10 && n < 300) begin tick(); n++; end
        checks++; if (l_vcc !== 8'h10) begin errors++; $display("FAIL en_find_row4: got %h expected %h", l_vcc, 8'h10); end
        repeat (5) tick();
        checks++; if (l_vcc !== 8'h10) begin errors++; $display("FAIL en_row4_slot1: got %h expected %h", l_vcc, 8'h10); end
        en = 1'b0;
        $display("enable low in slot 1 of row 4");
        dark = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (l_vcc === 8'h00 && l_green === 8'hff && l_red === 8'hff && fs === 1'b0) dark++;
        end
        checks++; if (dark !== 10) begin errors++; $display("FAIL en_dark: got %0d expected 10", dark); end
        en = 1'b1;
        $display("enable high");
        rem = 0;
        tick();
        while (l_vcc === 8'h10 && rem < 50) begin rem++; tick(); end
        checks++; if (rem !== 6) begin errors++; $display("FAIL en_remaining: got %0d expected 6", rem); end
        blank = 0;
        while (l_vcc === 8'h00 && blank < 50) begin blank++; tick(); end
        checks++; if (blank !== 2) begin errors++; $display("FAIL en_blank_after: got %0d expected 2", blank); end
        checks++; if (l_vcc !== 8'h20) begin errors++; $display("FAIL en_next_row: got %h expected %h", l_vcc, 8'h20); end
    endtask

    task automatic test_reset_mid();
        int n, lit;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        $display("swap request before reset");
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rm_pending_pre: got %b expected 1", pending); end
        n = 0;
        while (l_vcc !== 8'h40 && n < 300) begin tick(); n++; end
        checks++; if (l_vcc !== 8'h40) begin errors++; $display("FAIL rm_find_row6: got %h expected %h", l_vcc, 8'h40); end
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        $display("reset asserted mid-row 6");
        checks++; if (l_vcc !== 8'h00) begin errors++; $display("FAIL rm_vcc: got %h expected %h", l_vcc, 8'h00); end
        checks++; if (l_green !== 8'hff || l_red !== 8'hff) begin errors++; $display("FAIL rm_cols: got %h/%h expected ff/ff", l_green, l_red); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rm_pending_drop: got %b expected 0", pending); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rm_q: got %h expected %h", q, 32'h0); end
        tick();
        rst = 1'b0;
        addr = 3'd3;
        tick();
        checks++; if (fs !== 1'b1 || l_vcc !== 8'h00) begin errors++; $display("FAIL rm_restart: got fs=%b vcc=%h expected fs=1 vcc=00", fs, l_vcc); end
        checks++; if (q !== 32'h0) begin errors++; $display("FAIL rm_buffer_cleared: got %h expected %h", q, 32'h0); end
        lit = 0;
        for (int i = 0; i < 112; i++) begin
            tick();
            if (l_green !== 8'hff || l_red !== 8'hff) lit++;
        end
        checks++; if (lit !== 0) begin errors++; $display("FAIL rm_blank_display: got %0d expected 0", lit); end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_pwm_levels();
        test_swap_pending();
        test_read_write();
        test_enable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_matrix_pwm_driver.md
# led_matrix_pwm_driver

Parametrised scan driver for a multiplexed bi-colour LED matrix with per-pixel PWM intensity, double-buffered frame storage and anti-ghosting row blanking. It sits between the CPU memory-mapped bus and the matrix pins. It is the successor to the fixed 8x8 on/off matrix driver: same row-scan scheme and same pin polarity, plus generalised geometry, intensity levels and tear-free frame swap.

## Interface
- ROWS, 8, number of matrix rows (≥2); RW = $clog2(ROWS)
- COLS, 8, number of columns per colour
- BW, 2, intensity bits per pixel per colour (≥1); NSLOT = 2^BW − 1
- PRESCALE, 1024, clocks per PWM slot (≥1)
- BLANK, 16, all-off clocks at start of each row (≥1)
- W (derived) = 2·COLS·BW, row word width
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- ADDR  in  RW  row address for CPU access to back buffer
- DATA  in  W  row write data; green col c = DATA[c·BW +: BW], red col c = DATA[COLS·BW + c·BW +: BW]
- WREN  in  1  write DATA to back buffer row ADDR
- Q  out  W  back-buffer read data for ADDR, registered
- SWAP  in  1  single-cycle request to exchange front/back at next frame boundary
- EN  in  1  scan enable; low = display dark, scan frozen
- SWAP_PENDING  out  1  swap requested, not yet performed
- FRAME_START  out  1  one-cycle pulse on first cycle of row 0
- L_GREEN  out  COLS  green column drive, active-low
- L_RED  out  COLS  red column drive, active-low
- L_VCC  out  ROWS  row drive, one-hot, active-high

## Operation
- Storage: two buffers of ROWS × W bits, register-based; front buffer scanned, back buffer owned by CPU port. Both cleared on reset; front index = 0.
- Write: WREN=1 stores DATA into back[ADDR] at the clock edge. ADDR ≥ ROWS (non-power-of-2 ROWS): write ignored, Q reads 0.
- Read: Q = back[ADDR] sampled at the edge; write-then-read same address returns new data one cycle later.
- Scan FSM, per row: BLANK state (BLANK clocks, L_VCC=0, columns all 1) → PWM state (NSLOT slots × PRESCALE clocks each) → next row, wrapping ROWS−1 → 0.
- In slot k (0..NSLOT−1): L_VCC[row]=1; column c colour driven low iff intensity(c) > k. Intensity 0 = dark, NSLOT = on for all slots.
- Row dwell = BLANK + NSLOT·PRESCALE clocks; frame = ROWS × dwell.
- Frame boundary = last clock of last slot of row ROWS−1. At that edge, if SWAP_PENDING=1: front index toggles, SWAP_PENDING clears.
- SWAP=1 sets SWAP_PENDING at next edge. SWAP while pending: no effect. SWAP on the boundary cycle with pending=0: pending set, swap waits for the following boundary.
- WREN on the swap edge writes the pre-swap back buffer (becomes front).
- EN=0: prescale/slot/row counters hold; outputs forced dark on next edge; writes, reads and swap request still operate, but a pending swap cannot complete. EN 0→1: resumes from held position.

## Timing
- Reset values: L_GREEN=all 1, L_RED=all 1, L_VCC=0, Q=0, SWAP_PENDING=0, FRAME_START=0; scan at row 0, BLANK state, counters 0. First row-0 BLANK cycle after reset release asserts FRAME_START.
- Outputs registered; pins change on the edge that enters each phase. No cycle with two L_VCC bits set; every row change passes ≥BLANK dark clocks.
- Front-buffer row data is latched at BLANK entry; writes to the front buffer are impossible, so a row never changes mid-dwell.
- Reset mid-frame: all outputs to reset values immediately (asynchronous), buffers cleared, pending swap dropped.

## Test plan
- ROWS=8,COLS=8,BW=2,PRESCALE=4,BLANK=2: after reset, L_VCC=0 for 2 clocks, then 8'h01 for 12 clocks, then 0 for 2, then 8'h02; FRAME_START every 112 clocks.
- Write row 3 green col0=3, col1=2, col2=1, col3=0; SWAP -> during row 3 L_GREEN[0] low 12 clocks, [1] low 8, [2] low 4, [3] never low.
- SWAP mid-frame -> SWAP_PENDING=1 until boundary; front unchanged until then; new image from next FRAME_START; second SWAP while pending ignored.
- Write then read ADDR=5 (DATA=32'hA5A5_0F0F) -> Q=32'hA5A5_0F0F one cycle later; front display unaffected before swap.
- EN=0 in slot 1 of row 4 -> pins dark next edge, counters frozen; EN=1 -> row 4 resumes slot 1 with remaining clocks.
- Assert RST mid-PWM of row 6 -> pins dark, L_VCC=0 same cycle; after release, row 0 BLANK and blank display (buffers zero).
